// File: rtl/mux_8_if.sv
// -----------------------------------------------------------------------------
// mux_8_if
// Signal bundle for the registered 8-to-1 single-bit multiplexer.
//
// Signals:
//   s0, s1, s2  select bits. s0 is the LSB, so sel = {s2,s1,s0}.
//   i0 .. i7    data inputs. Input k is chosen when sel == k.
//   o           registered selected data bit.
//
// Modports:
//   master  Drives the selects and data, and observes o (producer/testbench).
//   slave   Receives the selects and data, and drives o (the mux_8 block).
// -----------------------------------------------------------------------------
interface mux_8_if;
    logic s0;
    logic s1;
    logic s2;
    logic i0;
    logic i1;
    logic i2;
    logic i3;
    logic i4;
    logic i5;
    logic i6;
    logic i7;
    logic o;

    modport master (
        output s0, s1, s2,
        output i0, i1, i2, i3, i4, i5, i6, i7,
        input  o
    );

    modport slave (
        input  s0, s1, s2,
        input  i0, i1, i2, i3, i4, i5, i6, i7,
        output o
    );
endinterface

// File: rtl/mux_8.sv
// -----------------------------------------------------------------------------
// mux_8
// Registered 8-to-1 single-bit multiplexer. sel = {s2,s1,s0} picks one of
// i0..i7, and the chosen bit is clocked into o.
//
// Parameters:
//   RESET_VAL   Value loaded into o on reset.
//
// Ports:
//   clk         Rising-edge clock.
//   rst         Asynchronous active-high reset. The user synchronises its release.
//   bus         mux_8_if.slave, which carries s0..s2 and i0..i7 in and o out.
//
// Build option:
//   MUX_8_INREG_EN  When defined, selects and data pass through an input
//                   register stage first, which gives 2-cycle latency. Those
//                   input registers reset to 0. When undefined, selection is
//                   combinational on the raw inputs and latency is 1 cycle.
// -----------------------------------------------------------------------------
module mux_8 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    mux_8_if.slave   bus
);

    logic [7:0] data_raw;
    logic [2:0] sel_raw;
    logic [7:0] data_use;
    logic [2:0] sel_use;
    logic [7:0] pick_term;
    logic       o_d;
    logic       o_q;

    assign data_raw = {bus.i7, bus.i6, bus.i5, bus.i4,
                       bus.i3, bus.i2, bus.i1, bus.i0};
    assign sel_raw  = {bus.s2, bus.s1, bus.s0};

`ifdef MUX_8_INREG_EN
    logic [7:0] data_q;
    logic [2:0] sel_q;

    // The input stage always clears to zero, whatever RESET_VAL is. On its own
    // this stage only adds latency, and nothing observes it directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            data_q <= data_raw;
            sel_q  <= sel_raw;
        end
    end

    assign data_use = data_q;
    assign sel_use  = sel_q;
`else
    assign data_use = data_raw;
    assign sel_use  = sel_raw;
`endif

    // Each product term is one decoded select ANDed with its data bit. All
    // eight codes are decoded, so no X can arise from known inputs.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pick
            assign pick_term[gi] = data_use[gi] & (sel_use == 3'(gi));
        end
    endgenerate

    assign o_d = |pick_term;

    // The output register keeps o glitch-free: it changes only on a clk edge
    // or when rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= RESET_VAL;
        end else begin
            o_q <= o_d;
        end
    end

    assign bus.o = o_q;

endmodule

// File: tb/tb_mux_8.sv
// -----------------------------------------------------------------------------
// tb_mux_8
// Directed self-checking bench for mux_8. Inputs change 1 ns after each rising
// edge. o is sampled 1 ns after the edge, or between edges for the reset cases.
// The expected values come from hand-computed constants or from a queue that
// tracks the configured latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_8;

`ifdef MUX_8_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic exp_q[$];

    mux_8_if bus();

    mux_8 #(.RESET_VAL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic exp);
        vec_cnt++;
        $display("[%0t] %s o=%b exp=%b", $time, tag, bus.o, exp);
        assert (bus.o === exp) else begin
            err_cnt++;
            $error("FAIL %s: o=%b expected=%b", tag, bus.o, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] d);
        {bus.s2, bus.s1, bus.s0} = sel;
        {bus.i7, bus.i6, bus.i5, bus.i4, bus.i3, bus.i2, bus.i1, bus.i0} = d;
    endtask

    // Apply one vector for one cycle. Once the latency queue is full, compare
    // o against the expectation that was pushed LAT vectors earlier.
    task automatic apply(input string tag, input logic [2:0] sel,
                         input logic [7:0] d, input logic exp);
        drive(sel, d);
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        if (exp_q.size() >= LAT) check(tag, exp_q.pop_front());
    endtask

    initial begin : stim
        logic [2:0] zero_order [8];
        logic       pat_exp    [8];
        zero_order = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd5, 3'd7};
        pat_exp    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Power-up reset: i0 is driven high under sel 0, and o must still hold 0.
        drive(3'd0, 8'h01);
        #12;
        check("reset_init", 1'b0);
        @(posedge clk); #1;
        check("reset_hold0", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        // Drive o to 1 first, so that the asynchronous reset shows a real drop.
        apply("prime", 3'd0, 8'h01, 1'b1);
        apply("prime", 3'd0, 8'h01, 1'b1);
        check("prime_hi", 1'b1);

        // Reset check. Inputs go to 0 and rst rises between edges.
        drive(3'd0, 8'h00);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", 1'b0);
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            check("rst_hold", 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_release", 1'b0);

        // All-zero sweep.
        for (int n = 0; n < 8; n++)
            apply($sformatf("zero_sel%0d", zero_order[n]), zero_order[n], 8'h00, 1'b0);

        // One-hot walk.
        for (int k = 0; k < 8; k++)
            for (int s = 0; s < 8; s++)
                apply($sformatf("onehot_k%0d_s%0d", k, s), 3'(s), 8'(1 << k), (s == k));

        // Pattern select: i7..i0 = 1010_0110.
        for (int s = 0; s < 8; s++)
            apply($sformatf("pattern_s%0d", s), 3'(s), 8'b1010_0110, pat_exp[s]);

        // Simultaneous change: sel goes 001 -> 110 while i6 goes 0 -> 1.
        apply("simul_pre", 3'd1, 8'h00, 1'b0);
        apply("simul", 3'd6, 8'h40, 1'b1);
        apply("simul_hold", 3'd6, 8'h40, 1'b1);

        // Mid-stream reset: a 2 ns pulse between edges while i3 = 1 and sel = 011.
        apply("mid_pre", 3'd3, 8'h08, 1'b1);
        apply("mid_pre", 3'd3, 8'h08, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst", 1'b0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        apply("mid_rec", 3'd3, 8'h08, 1'b1);
        apply("mid_rec", 3'd3, 8'h08, 1'b1);

        // Reset held across edges while the selected input is 1: o must stay low.
        #3;
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            check("mid_hold", 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        apply("hold_rec", 3'd3, 8'h08, 1'b1);
        apply("hold_rec", 3'd3, 8'h08, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
